// File: rtl/riscv_mdu_pkg.sv
// Shared types and decode helpers for the RV32M iterative multiply/divide unit.
package riscv_mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_t;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_t;

  function automatic logic is_div(mdu_op_t op);
    return op[2];
  endfunction

  // MUL needs no sign handling: the low half is identical for signed and unsigned.
  function automatic logic is_signed_a(mdu_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(mdu_op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/riscv_mdu_if.sv
// Command/result bundle between the execute stage and the multiply/divide unit.
interface riscv_mdu_if #(
  parameter int N = 32
);
  // Start is sampled only when the unit is IDLE or DONE; Done pulses for one
  // cycle with Result valid, and Result holds until the next completion.
  logic         Start;
  logic [2:0]   MDUOp;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] Result;
  logic         Busy;
  logic         Done;

  modport master (
    output Start, MDUOp, A, B,
    input  Result, Busy, Done
  );

  modport slave (
    input  Start, MDUOp, A, B,
    output Result, Busy, Done
  );
endinterface

// File: rtl/riscv_mdu.sv
// Iterative RV32M multiply/divide: one shift-add or restoring-divide step per
// CALC cycle over a shared 2N-bit register, signs applied in FIX.
module riscv_mdu
  import riscv_mdu_pkg::*;
#(
  parameter int N    = 32,
  parameter int logN = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  riscv_mdu_if.slave    bus,
  output mdu_state_t    dbg_state
);

  mdu_state_t      state;
  mdu_op_t         op_r;
  logic [logN-1:0] cnt;
  logic [2*N-1:0]  prod;
  logic [N-1:0]    mcand;
  logic            a_neg;
  logic            b_neg;
  logic            spec;
  logic [N-1:0]    result_r;
  logic            busy_r;
  logic            done_r;

  mdu_op_t         op_in;
  logic            a_neg_in;
  logic            b_neg_in;
  logic [N-1:0]    a_mag;
  logic [N-1:0]    b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic [N-1:0]    spec_val;

  logic [N:0]      mul_sum;
  logic [2*N-1:0]  mul_next;
  logic [N:0]      div_trial;
  logic [N:0]      div_sub;
  logic            div_ge;
  logic [2*N-1:0]  div_next;

  logic [2*N-1:0]  prod_fin;
  logic [N-1:0]    quo;
  logic [N-1:0]    rem;
  logic [N-1:0]    fix_result;

  // Operand decode for the accepting edge.
  always_comb begin
    op_in    = mdu_op_t'(bus.MDUOp);
    a_neg_in = is_signed_a(op_in) & bus.A[N-1];
    b_neg_in = is_signed_b(op_in) & bus.B[N-1];
    a_mag    = a_neg_in ? (~bus.A + 1'b1) : bus.A;
    b_mag    = b_neg_in ? (~bus.B + 1'b1) : bus.B;
    div_zero = is_div(op_in) && (bus.B == '0);
    div_ovf  = (op_in == OP_DIV || op_in == OP_REM) &&
               (bus.A == {1'b1, {(N-1){1'b0}}}) && (bus.B == '1);
    spec_val = '0;
    if (div_zero) begin
      spec_val = op_in[1] ? bus.A : '1;
    end else if (div_ovf) begin
      spec_val = op_in[1] ? '0 : bus.A;
    end
  end

  // One iteration of each algorithm; the low half of prod holds the
  // multiplier (multiply) or the dividend shifting into quotient (divide).
  always_comb begin
    mul_sum   = {1'b0, prod[2*N-1:N]} + (prod[0] ? {1'b0, mcand} : '0);
    mul_next  = {mul_sum, prod[N-1:1]};
    div_trial = {prod[2*N-1:N], prod[N-1]};
    div_sub   = div_trial - {1'b0, mcand};
    div_ge    = (div_trial >= {1'b0, mcand});
    div_next  = {(div_ge ? div_sub[N-1:0] : div_trial[N-1:0]), prod[N-2:0], div_ge};
  end

  always_comb begin
    prod_fin   = (a_neg ^ b_neg) ? (~prod + 1'b1) : prod;
    quo        = (a_neg ^ b_neg) ? (~prod[N-1:0] + 1'b1) : prod[N-1:0];
    rem        = a_neg ? (~prod[2*N-1:N] + 1'b1) : prod[2*N-1:N];
    fix_result = '0;
    if (spec) begin
      fix_result = prod[N-1:0];
    end else begin
      case (op_r)
        OP_MUL:                       fix_result = prod_fin[N-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fin[2*N-1:N];
        OP_DIV, OP_DIVU:              fix_result = quo;
        default:                      fix_result = rem;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MDU_IDLE;
      op_r     <= OP_MUL;
      cnt      <= '0;
      prod     <= '0;
      mcand    <= '0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      spec     <= 1'b0;
      result_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        MDU_IDLE, MDU_DONE: begin
          if (bus.Start) begin
            op_r   <= op_in;
            a_neg  <= a_neg_in;
            b_neg  <= b_neg_in;
            mcand  <= b_mag;
            cnt    <= logN'(N-1);
            busy_r <= 1'b1;
            spec   <= div_zero | div_ovf;
            if (div_zero | div_ovf) begin
              prod  <= {{N{1'b0}}, spec_val};
              state <= MDU_FIX;
            end else begin
              prod  <= {{N{1'b0}}, a_mag};
              state <= MDU_CALC;
            end
          end else begin
            state <= MDU_IDLE;
          end
        end
        MDU_CALC: begin
          prod <= is_div(op_r) ? div_next : mul_next;
          if (cnt == '0) begin
            state <= MDU_FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MDU_FIX: begin
          result_r <= fix_result;
          busy_r   <= 1'b0;
          done_r   <= 1'b1;
          state    <= MDU_DONE;
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

  assign bus.Result = result_r;
  assign bus.Busy   = busy_r;
  assign bus.Done   = done_r;
  assign dbg_state  = state;

endmodule
